// File: rtl/jedro_1_imem_loader_pkg.sv
// Shared definitions for the jedro_1 instruction-memory loader.
//   imem_ldr_state_e    : loader FSM state encoding
//   IMEM_LDR_HDR_BYTES  : bytes in the stream header (16-bit word count)
//   IMEM_LDR_WORD_BYTES : bytes per instruction word
package jedro_1_imem_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE   = 3'd0,
        LDR_HDR_LO = 3'd1,
        LDR_HDR_HI = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_WRITE  = 3'd4,
        LDR_DONE   = 3'd5
    } imem_ldr_state_e;

    localparam int IMEM_LDR_HDR_BYTES  = 2;
    localparam int IMEM_LDR_WORD_BYTES = 4;

endpackage

// File: rtl/jedro_1_imem_loader_byte_packer.sv
// Assembles a little-endian 32-bit word from a byte stream.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clear_i      : restart assembly (counter and word back to zero)
//   byte_en_i    : a byte is accepted this cycle
//   byte_i       : the accepted byte
//   word_o       : assembled word; byte k ends up in bits [8k+7:8k]
//   word_done_o  : strobe, high in the cycle the last byte of a word is accepted
module jedro_1_byte_packer
    import jedro_1_imem_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    localparam int CNT_W = $clog2(IMEM_LDR_WORD_BYTES);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(IMEM_LDR_WORD_BYTES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      word_q, word_d;

    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
        end else if (byte_en_i) begin
            // Shifting in from the top leaves the first byte in [7:0]
            // once all four have arrived.
            word_d = {byte_i, word_q[31:8]};
            cnt_d  = cnt_q + 1'b1;  // wraps back to 0 after the last byte
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word_o      = word_q;
    assign word_done_o = byte_en_i && !clear_i && (cnt_q == LAST_BYTE);

endmodule

// File: rtl/jedro_1_imem_loader.sv
// Loads a program image from a byte stream into instruction RAM.
// Stream: 16-bit word count N (LSB first), then N words (LSB byte first).
// Words are written to BASE_ADDR + 4*i; the core is held in reset until a
// non-empty image has been completely written.
//   clk_i, rst_i                  : clock, asynchronous active-high reset
//   start_i                       : begin a load (honoured in IDLE/DONE)
//   byte_valid_i/_data_i/ready_o  : input byte stream handshake
//   mem_wr_valid_o/_addr_o/_wdata_o, mem_wr_ready_i : RAM write handshake
//   core_rst_o                    : core reset, released only after a good load
//   busy_o, done_o, error_o       : load status (done/error valid in DONE)
//
// Handshakes: a byte moves on a rising edge when byte_valid_i && byte_ready_o;
// a write moves on a rising edge when mem_wr_valid_o && mem_wr_ready_i. While
// a write is pending its address/data are held and no byte is accepted.
module jedro_1_imem_loader
    import jedro_1_imem_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_data_i,
    output logic                  byte_ready_o,
    output logic                  mem_wr_valid_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                  mem_wr_ready_i,
    output logic                  core_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o
);

    imem_ldr_state_e state_q, state_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     word_idx_q, word_idx_d;
    logic            done_q, done_d;
    logic            error_q, error_d;

    logic            byte_fire;
    logic            wr_fire;
    logic            pack_clear;
    logic            pack_en;
    logic            word_done;
    logic [31:0]     word;

    assign byte_fire = byte_valid_i && byte_ready_o;
    assign wr_fire   = mem_wr_valid_o && mem_wr_ready_i;
    assign pack_en   = byte_fire && (state_q == LDR_DATA);

    jedro_1_byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (pack_clear),
        .byte_en_i   (pack_en),
        .byte_i      (byte_data_i),
        .word_o      (word),
        .word_done_o (word_done)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        done_d     = done_q;
        error_d    = error_q;
        pack_clear = 1'b0;
        case (state_q)
            LDR_IDLE, LDR_DONE: begin
                if (start_i) begin
                    state_d    = LDR_HDR_LO;
                    word_idx_d = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    pack_clear = 1'b1;
                end
            end
            LDR_HDR_LO: begin
                if (byte_fire) begin
                    count_d[7:0] = byte_data_i;
                    state_d      = LDR_HDR_HI;
                end
            end
            LDR_HDR_HI: begin
                if (byte_fire) begin
                    count_d[15:8] = byte_data_i;
                    // An empty image is a failed load: the core stays in reset.
                    if ({byte_data_i, count_q[7:0]} == 16'd0) begin
                        state_d = LDR_DONE;
                        error_d = 1'b1;
                    end else begin
                        state_d = LDR_DATA;
                    end
                end
            end
            LDR_DATA: begin
                if (word_done) begin
                    state_d = LDR_WRITE;
                end
            end
            LDR_WRITE: begin
                if (wr_fire) begin
                    // count_q >= 1 here, so count_q - 1 cannot underflow.
                    if (word_idx_q == count_q - 16'd1) begin
                        state_d = LDR_DONE;
                        done_d  = 1'b1;
                    end else begin
                        word_idx_d = word_idx_q + 16'd1;
                        state_d    = LDR_DATA;
                    end
                end
            end
            default: begin
                state_d = LDR_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= LDR_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // Word index scaled to a byte offset (x4), then wrapped into the address space.
    assign mem_addr_o     = BASE_ADDR + ADDR_WIDTH'({word_idx_q, 2'b00});
    assign mem_wdata_o    = word;
    assign mem_wr_valid_o = (state_q == LDR_WRITE);
    assign byte_ready_o   = (state_q == LDR_HDR_LO) || (state_q == LDR_HDR_HI) ||
                            (state_q == LDR_DATA);
    assign busy_o         = byte_ready_o || (state_q == LDR_WRITE);
    assign core_rst_o     = !((state_q == LDR_DONE) && !error_q);
    assign done_o         = done_q;
    assign error_o        = error_q;

endmodule

// File: tb/tb_jedro_1_imem_loader.sv
module tb_jedro_1_imem_loader;

    localparam logic [31:0] BASE = 32'h0;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_wr_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_ready;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;

    jedro_1_imem_loader #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .byte_valid_i   (byte_valid),
        .byte_data_i    (byte_data),
        .byte_ready_o   (byte_ready),
        .mem_wr_valid_o (mem_wr_valid),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_wr_ready_i (mem_wr_ready),
        .core_rst_o     (core_rst),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Record every write that transfers at the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && mem_wr_valid === 1'b1 && mem_wr_ready === 1'b1)
            got_q.push_back({mem_addr, mem_wdata});
    end

    // A stalled write must keep address/data and must not take bytes.
    logic        stalled_prev = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst === 1'b0 && stalled_prev) begin
            chk("stall_valid_held", 64'(mem_wr_valid), 64'(1));
            chk("stall_addr_held", 64'(mem_addr), 64'(prev_addr));
            chk("stall_data_held", 64'(mem_wdata), 64'(prev_data));
        end
        if (rst === 1'b0 && mem_wr_valid === 1'b1 && mem_wr_ready === 1'b0)
            chk("stall_no_byte_ready", 64'(byte_ready), 64'(0));
        stalled_prev = (rst === 1'b0) && (mem_wr_valid === 1'b1) && (mem_wr_ready === 1'b0);
        prev_addr    = mem_addr;
        prev_data    = mem_wdata;
    end

    // RAM ready: 0 = always ready, 1 = random, 2 = 5-cycle stall per write.
    int rdy_mode  = 0;
    int stall_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: mem_wr_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (mem_wr_valid && stall_cnt < 5) begin
                    mem_wr_ready = 1'b0;
                    stall_cnt++;
                end else begin
                    mem_wr_ready = 1'b1;
                    if (!mem_wr_valid) stall_cnt = 0;
                end
            end
            default: mem_wr_ready = 1'b1;
        endcase
    end

    // ---------------- driver tasks ----------------
    logic [31:0] img[$];

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        // One cycle after start the load is running and the core is in reset.
        chk("start_core_rst", 64'(core_rst), 64'(1));
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_flags_clear", 64'({done, error}), 64'(0));
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  tmo;
        bit  acc;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        tmo = 0;
        forever begin
            @(negedge clk);
            acc = byte_ready;
            @(posedge clk); #1;
            if (acc) break;
            tmo++;
            if (tmo > 500) begin
                chk("byte_timeout", 64'(0), 64'(1));
                break;
            end
        end
        byte_valid = 1'b0;
    endtask

    // Reference model: N words land at BASE + 4*i in order; N==0 is an error
    // that keeps the core in reset; latency follows the per-byte/per-write cost.
    task automatic run_load(input int n, input bit gaps, input int mode,
                            input bit exp_err, input int exp_lat);
        logic [15:0] nn;
        int          t0;
        bit          seen;
        logic [63:0] g;
        logic [63:0] e;
        nn       = 16'(n);
        rdy_mode = mode;
        stall_cnt = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++)
            exp_q.push_back({BASE + 32'(4 * i), img[i]});
        do_start();
        got_q.delete();
        t0 = cyc;
        send_byte(nn[7:0], gaps);
        send_byte(nn[15:8], gaps);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < 4; k++)
                send_byte(img[i][8*k +: 8], gaps);
        seen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (done || error) begin
                seen = 1'b1;
                break;
            end
        end
        chk("load_finished", 64'(seen), 64'(1));
        if (exp_lat >= 0) chk("latency", 64'(cyc - t0), 64'(exp_lat));
        chk("error_o", 64'(error), 64'(exp_err));
        chk("done_o", 64'(done), 64'(!exp_err));
        chk("core_rst_o", 64'(core_rst), 64'(exp_err));
        chk("busy_o", 64'(busy), 64'(0));
        chk("write_count", 64'(got_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk("write_addr", 64'(g[63:32]), 64'(e[63:32]));
            chk("write_data", 64'(g[31:0]), 64'(e[31:0]));
        end
        rdy_mode = 0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        bit          gaps;
        int          mode;
        bit          exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_byte_ready"}, 64'(byte_ready), 64'(0));
        chk({tag, "_wr_valid"}, 64'(mem_wr_valid), 64'(0));
        chk({tag, "_core_rst"}, 64'(core_rst), 64'(1));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_done_err"}, 64'({done, error}), 64'(0));
        chk({tag, "_addr"}, 64'(mem_addr), 64'(BASE));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
    endtask

    initial begin
        int n;
        bit gaps;
        int mode;
        int lat;

        // N=2 image from the bring-up program; then error, gaps, stalls.
        vecs[0] = '{2, 32'h00100093, 32'h00208093, 32'h0, 1'b0, 0, 1'b0, 12};
        vecs[1] = '{0, 32'h0, 32'h0, 32'h0, 1'b0, 0, 1'b1, 2};
        vecs[2] = '{2, 32'h00100093, 32'h00208093, 32'h0, 1'b1, 0, 1'b0, -1};
        vecs[3] = '{1, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 0, 1'b0, 7};
        vecs[4] = '{3, 32'h11223344, 32'hA5A55A5A, 32'hFFFFFFFF, 1'b0, 2, 1'b0, 32};
        vecs[5] = '{3, 32'h01020304, 32'h80000001, 32'h7F7F7F7F, 1'b1, 1, 1'b0, -1};

        rst          = 1'b1;
        start        = 1'b0;
        byte_valid   = 1'b0;
        byte_data    = 8'h00;
        mem_wr_ready = 1'b1;
        #22;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("idle");

        foreach (vecs[v]) begin
            img.delete();
            img.push_back(vecs[v].w0);
            img.push_back(vecs[v].w1);
            img.push_back(vecs[v].w2);
            run_load(vecs[v].n, vecs[v].gaps, vecs[v].mode, vecs[v].exp_err, vecs[v].exp_lat);
        end

        // Reset after the 6th byte (header + first word): abort at once.
        img.delete();
        img.push_back(32'hCAFEF00D);
        img.push_back(32'h0BADC0DE);
        rdy_mode = 0;
        do_start();
        got_q.delete();
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8], 1'b0);
        rst = 1'b1;
        #1;
        check_idle_outputs("midload_rst");
        chk("midload_no_write", 64'(got_q.size()), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        img.delete();
        img.push_back(32'h12345678);
        run_load(1, 1'b0, 0, 1'b0, 7);

        // Restart from DONE, then randomized loads.
        for (int r = 0; r < 8; r++) begin
            n    = $urandom_range(1, 5);
            gaps = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back($urandom);
            if (gaps || mode == 1) lat = -1;
            else if (mode == 2) lat = 2 + 10 * n;
            else lat = 2 + 5 * n;
            run_load(n, gaps, mode, 1'b0, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
